instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage for the 10-bit single-issue CPU. Owns the program counter, drives the address of the combinational instruction ROM, and registers each fetched word with its address for the decode stage. Handles back-pressure from decode, branch/jump redirects from execute, and stops fetching once the halt word is fetched.

## Interface
- ADDR_W, 10, PC / ROM address width
- INSTR_W, 10, instruction width
- RESET_PC, 10'd1, first address fetched after reset
- HALT_WORD, 10'b0010000010, halt encoding
- NOP_WORD, 10'b0010000011, bubble inserted on flush and after reset
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rom_addr  out  ADDR_W  equals pc (combinational from the PC register)
- rom_data  in  INSTR_W  ROM read data, valid in the same cycle as rom_addr
- stall  in  1  decode not ready; hold all fetch state
- redirect_valid  in  1  execute took a branch/jump
- redirect_addr  in  ADDR_W  target address
- instr  out  INSTR_W  registered instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr is a real, on-path instruction
- halted  out  1  fetch stopped on HALT_WORD

## Operation
- States: RUN, HALTED.
- Reset (any state, any inputs): pc=RESET_PC, instr=NOP_WORD, instr_pc=0, instr_valid=0, halted=0, state=RUN.
- RUN, priority order:
  - redirect_valid: pc<=redirect_addr; instr<=NOP_WORD; instr_valid<=0; instr_pc unchanged. Applies even when stall=1. A halt word on rom_data in the same cycle is discarded.
  - stall (no redirect): pc, instr, instr_pc, instr_valid all hold.
  - Otherwise: instr<=rom_data; instr_pc<=pc; instr_valid<=1. If rom_data==HALT_WORD, pc holds, state<=HALTED, and halted<=1. Otherwise pc<=pc+1.
- PC arithmetic: ADDR_W-bit unsigned. Wraps from 1023 to 0 with no flag.
- HALTED:
  - The halt word stays on instr with instr_valid=1 until decode accepts it, i.e. the first cycle with stall=0.
  - The next cycle, instr<=NOP_WORD and instr_valid<=0.
  - pc is frozen, and redirect_valid is ignored.
  - Only reset leaves HALTED.

## Timing
- Fetch latency is 1 cycle: a word at address A appears on instr the cycle after pc==A.
- First valid instruction: the first rising edge after reset deasserts captures RESET_PC. instr_valid=1 from that edge.
- Throughput is one instruction per cycle when stall=0.
- Redirect penalty is one bubble cycle (instr_valid=0). The target instruction is valid on the second edge after redirect.
- The outputs are a plain registered valid/stall pair. Decode consumes instr on any edge where instr_valid=1 and stall=0.
- There is no combinational path from stall or redirect to rom_addr. rom_addr changes only on clock edges.

## Configuration
- FETCH_COUNT_EN defined:
  - Adds output fetch_count[15:0], reset to 0.
  - It increments on every edge where a valid instruction is captured, including the halt word.
  - It saturates at 16'hFFFF.
- FETCH_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds ADDR_W, INSTR_W, HALT_WORD, NOP_WORD, and the fetch state enum (RUN, HALTED). Decode and the ROM use the same constants.
- One sub-module, fetch_pc: the PC register with reset load, increment, redirect load and freeze. The FSM and output register stay in instr_fetch.

## Test plan
- Reset, then free-run over a ROM holding words W1..W4 at addresses 1..4 -> instr=W1..W4 on consecutive cycles, instr_pc=1..4, instr_valid=1. During reset, instr=NOP_WORD and instr_valid=0.
- Hold stall=1 for 3 cycles while instr=W2 -> instr, instr_pc=2 and rom_addr=3 unchanged. W3 appears on the first edge after stall drops.
- Assert redirect_valid with redirect_addr=4 while pc=11 -> one cycle with instr=NOP_WORD and instr_valid=0, then instr_pc=4.
- Put HALT_WORD at address 12 -> instr=HALT_WORD, instr_pc=12, halted=1. Next cycle, instr_valid=0 and pc stays 12. A later redirect_valid has no effect. Reset restores pc=1 and halted=0.
- Assert redirect_valid in the same cycle HALT_WORD is on rom_data -> halted stays 0 and the target is fetched. Also assert redirect while stall=1 -> the redirect is taken.
- Preload pc to 1023 via redirect -> fetches 1023 then 0. With FETCH_COUNT_EN defined, fetch_count matches the number of valid deliveries (e.g. 4 after the first scenario).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch state encoding and the fetch->decode bundle.
package cpu_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 10;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 10'd1;
  localparam logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010;
  localparam logic [INSTR_W-1:0] NOP_WORD  = 10'b0010000011;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset load, redirect load, increment, otherwise frozen.
module fetch_pc
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (advance) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, ROM address, registered instr bundle, halt FSM.
// Optional FETCH_COUNT_EN adds a saturating fetch_count output.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  fetch_state_t      state, state_d;
  if_id_t            out_q, out_d;
  logic [ADDR_W-1:0] pc;
  logic              load, advance, capture;

  fetch_pc u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (redirect_addr),
    .advance   (advance),
    .pc        (pc)
  );

  always_comb begin
    state_d = state;
    out_d   = out_q;
    load    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state)
      RUN: begin
        if (redirect_valid) begin
          load        = 1'b1;
          out_d.instr = NOP_WORD;
          out_d.valid = 1'b0;
        end else if (!stall) begin
          capture = 1'b1;
          out_d   = '{instr: rom_data, pc: pc, valid: 1'b1};
          if (rom_data == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HALTED: begin
        // halt word leaves once decode has taken it
        if (!stall) begin
          out_d.instr = NOP_WORD;
          out_d.valid = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      out_q <= '{instr: NOP_WORD, pc: '0, valid: 1'b0};
    end else begin
      state <= state_d;
      out_q <= out_d;
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (capture && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

  assign rom_addr    = pc;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;
  assign instr_valid = out_q.valid;
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector table plus randomized run against a rule-level model.
module tb_instr_fetch;

  localparam logic [9:0] HALT = 10'b0010000010;
  localparam logic [9:0] NOP  = 10'b0010000011;

  logic       clk = 1'b0;
  logic       reset, stall, redirect_valid;
  logic [9:0] redirect_addr, rom_addr, rom_data;
  logic [9:0] instr, instr_pc;
  logic       instr_valid, halted;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  logic [9:0] rom [1024];
  int passed = 0;
  int total  = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  typedef struct {
    bit         rst, st, rv;
    logic [9:0] ra;
    logic [9:0] e_instr, e_pc;
    bit         e_valid, e_halt;
    logic [9:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] w(int a);
    logic [9:0] t;
    t = a[9:0];
    return t ^ 10'h155;
  endfunction

  function automatic void add(bit rst, bit st, bit rv, int ra,
                              logic [9:0] ei, int ep, bit ev,
                              bit eh, int ea);
    vec_t v;
    v.rst = rst; v.st = st; v.rv = rv; v.ra = ra[9:0];
    v.e_instr = ei; v.e_pc = ep[9:0];
    v.e_valid = ev; v.e_halt = eh; v.e_addr = ea[9:0];
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step(bit rst, bit st, bit rv, logic [9:0] ra);
    @(negedge clk);
    reset = rst; stall = st;
    redirect_valid = rv; redirect_addr = ra;
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic [9:0]  m_pc, m_instr, m_ipc;
  bit          m_valid, m_halt;
  logic [15:0] m_cnt;

  function automatic void model(bit rst, bit st, bit rv, logic [9:0] ra);
    logic [9:0] word;
    word = rom[m_pc];
    if (rst) begin
      m_pc = 10'd1; m_instr = NOP; m_ipc = 0;
      m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (!st) begin
        m_instr = NOP; m_valid = 0;
      end
    end else if (rv) begin
      m_pc = ra; m_instr = NOP; m_valid = 0;
    end else if (!st) begin
      m_instr = word; m_ipc = m_pc; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (word == HALT) m_halt = 1;
      else m_pc = m_pc + 10'd1;
    end
  endfunction

  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_addr = 0;
    for (int a = 0; a < 1024; a++) rom[a] = w(a);
    rom[12] = HALT;

    add(1, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(1, 0, 0, 0, NOP, 0, 0, 0, 1);
    for (int a = 1; a <= 2; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, w(2), 2, 1, 0, 3);
    for (int a = 3; a <= 10; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    add(0, 0, 1, 4, NOP, 10, 0, 0, 4);
    for (int a = 4; a <= 11; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    add(0, 0, 0, 0, HALT, 12, 1, 1, 12);
    add(0, 1, 0, 0, HALT, 12, 1, 1, 12);
    add(0, 1, 1, 7, HALT, 12, 1, 1, 12);
    add(0, 0, 0, 0, NOP, 12, 0, 1, 12);
    add(0, 0, 1, 5, NOP, 12, 0, 1, 12);
    add(0, 0, 0, 0, NOP, 12, 0, 1, 12);
    add(1, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 1, 12, NOP, 0, 0, 0, 12);
    add(0, 0, 1, 20, NOP, 0, 0, 0, 20);
    add(0, 0, 0, 0, w(20), 20, 1, 0, 21);
    add(0, 1, 1, 1023, NOP, 20, 0, 0, 1023);
    add(0, 0, 0, 0, w(1023), 1023, 1, 0, 0);
    add(0, 0, 0, 0, w(0), 0, 1, 0, 1);
    add(0, 0, 0, 0, w(1), 1, 1, 0, 2);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].rv, tbl[i].ra);
      chk($sformatf("v%0d instr", i), 16'(instr), 16'(tbl[i].e_instr));
      chk($sformatf("v%0d instr_pc", i), 16'(instr_pc), 16'(tbl[i].e_pc));
      chk($sformatf("v%0d valid", i), 16'(instr_valid), 16'(tbl[i].e_valid));
      chk($sformatf("v%0d halted", i), 16'(halted), 16'(tbl[i].e_halt));
      chk($sformatf("v%0d rom_addr", i), 16'(rom_addr), 16'(tbl[i].e_addr));
    end

    for (int a = 0; a < 1024; a++) begin
      rom[a] = 10'($urandom);
      if ($urandom_range(63) == 0) rom[a] = HALT;
    end
    model(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit rst, st, rv;
      logic [9:0] ra;
      rst = ($urandom_range(99) < 2);
      st  = ($urandom_range(99) < 30);
      rv  = ($urandom_range(99) < 10);
      ra  = 10'($urandom);
      if ($urandom_range(9) == 0) ra = 10'd1020;
      model(rst, st, rv, ra);
      step(rst, st, rv, ra);
      chk($sformatf("r%0d instr", i), 16'(instr), 16'(m_instr));
      chk($sformatf("r%0d instr_pc", i), 16'(instr_pc), 16'(m_ipc));
      chk($sformatf("r%0d valid", i), 16'(instr_valid), 16'(m_valid));
      chk($sformatf("r%0d halted", i), 16'(halted), 16'(m_halt));
      chk($sformatf("r%0d rom_addr", i), 16'(rom_addr), 16'(m_pc));
`ifdef FETCH_COUNT_EN
      chk($sformatf("r%0d fetch_count", i), fetch_count, m_cnt);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
